fpu_addsub_seq: RTL and testbench

//  Parametrised sequential floating-point adder/subtractor; successor to the fixed 32-bit fpu.

---
 rtl/fpu_addsub_seq.sv | 204 ++++++++++++++++++++
 tb/tb_fpu_addsub_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_seq.sv
// Sequential floating-point adder/subtractor.
// Word format {sign, EXP_W exponent, MANT_W fraction}, bias 2^(EXP_W-1)-1,
// hidden leading 1, no denormals (exp=0 is zero), exp=all-ones is infinity.
// One operation walks IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
// The result is rounded to nearest-even, and a one-hot status word
// {EXACT, OVERFLOW, UNDERFLOW, INEXACT} is returned with it.
module fpu_addsub_seq #(
  parameter int EXP_W  = 6,
  parameter int MANT_W = 25
) (
  input  logic                      clock100KHz,
  input  logic                      reset,
  input  logic                      start_in,
  input  logic                      op_sub_in,
  input  logic [EXP_W+MANT_W:0]     op_A_in,
  input  logic [EXP_W+MANT_W:0]     op_B_in,
  output logic                      busy_out,
  output logic                      done_out,
  output logic [EXP_W+MANT_W:0]     data_out,
  output logic [3:0]                status_out
);

  localparam int W   = 1 + EXP_W + MANT_W;
  localparam int M   = MANT_W + 1;
  localparam int EXT = M + 3;
  localparam int EW  = EXP_W + 2;

  localparam logic [3:0] ST_EXACT     = 4'b1000;
  localparam logic [3:0] ST_OVERFLOW  = 4'b0100;
  localparam logic [3:0] ST_UNDERFLOW = 4'b0010;
  localparam logic [3:0] ST_INEXACT   = 4'b0001;

  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic [W-1:0]           r_dataOut;
  logic [3:0]             r_statusOut;
  logic [W-1:0]           r_opA;
  logic [W-1:0]           r_opB;
  logic                   r_sign;
  logic                   r_effSub;
  logic                   r_inf;
  logic signed [EW-1:0]   r_expL;
  logic [EXT-1:0]         r_mantL;
  logic [EXT-1:0]         r_mantS;
  logic [EXT:0]           r_sum;

  // Alignment datapath: unpack the captured operands and order them by magnitude.
  // A zero exponent means the operand is zero, so its fraction is ignored.
  logic [EXP_W-1:0]   w_expA, w_expB, w_expBig, w_expSmall;
  logic [MANT_W-1:0]  w_fracA, w_fracB, w_fracBig, w_fracSmall;
  logic               w_swap, w_signBig, w_inf;
  logic [EXT-1:0]     w_extBig, w_extSmall, w_alignedSmall;
  logic [31:0]        w_diff32, w_shamt;
  logic [2*EXT-1:0]   w_alignFull;

  assign w_expA      = r_opA[W-2:MANT_W];
  assign w_expB      = r_opB[W-2:MANT_W];
  assign w_fracA     = (w_expA == '0) ? '0 : r_opA[MANT_W-1:0];
  assign w_fracB     = (w_expB == '0) ? '0 : r_opB[MANT_W-1:0];
  assign w_swap      = {w_expB, w_fracB} > {w_expA, w_fracA};
  assign w_expBig    = w_swap ? w_expB : w_expA;
  assign w_expSmall  = w_swap ? w_expA : w_expB;
  assign w_fracBig   = w_swap ? w_fracB : w_fracA;
  assign w_fracSmall = w_swap ? w_fracA : w_fracB;
  assign w_signBig   = w_swap ? r_opB[W-1] : r_opA[W-1];
  assign w_inf       = (w_expA == '1) | (w_expB == '1);
  assign w_extBig    = {w_expBig != '0, w_fracBig, 3'b000};
  assign w_extSmall  = {w_expSmall != '0, w_fracSmall, 3'b000};
  // Shifting by EXT already pushes every bit into the sticky half, so larger
  // differences are clamped there instead of losing bits off the end.
  assign w_diff32    = 32'(w_expBig) - 32'(w_expSmall);
  assign w_shamt     = (w_diff32 > 32'(EXT)) ? 32'(EXT) : w_diff32;
  assign w_alignFull = {w_extSmall, {EXT{1'b0}}} >> w_shamt;
  assign w_alignedSmall = {w_alignFull[2*EXT-1:EXT+1],
                           w_alignFull[EXT] | (|w_alignFull[EXT-1:0])};

  // Rounding datapath: round-to-nearest-even on guard/round/sticky; a carry
  // out of the mantissa renormalises by one place and bumps the exponent.
  logic [M-1:0]          w_mantR;
  logic                  w_guard, w_round, w_sticky, w_inexact, w_rndUp, w_carry;
  logic [M:0]            w_mantInc;
  logic [MANT_W-1:0]     w_fracFinal;
  logic signed [EW-1:0]  w_expFinal;
  logic                  w_ovf, w_unf, w_zero;

  assign w_mantR     = r_sum[EXT-1:3];
  assign w_guard     = r_sum[2];
  assign w_round     = r_sum[1];
  assign w_sticky    = r_sum[0];
  assign w_inexact   = w_guard | w_round | w_sticky;
  assign w_rndUp     = w_guard & (w_round | w_sticky | w_mantR[0]);
  assign w_mantInc   = {1'b0, w_mantR} + {{M{1'b0}}, w_rndUp};
  assign w_carry     = w_mantInc[M];
  assign w_fracFinal = w_carry ? w_mantInc[M-1:1] : w_mantInc[MANT_W-1:0];
  assign w_expFinal  = r_expL + {{(EW-1){1'b0}}, w_carry};
  assign w_ovf       = (w_expFinal >= EXP_MAX);
  assign w_unf       = (w_expFinal < EXP_ONE);
  assign w_zero      = (r_sum == '0);

  // Result and status selection, highest-priority condition first.
  logic [W-1:0] w_resData;
  logic [3:0]   w_resStat;

  always_comb begin
    w_resData = '0;
    w_resStat = ST_EXACT;
    if (r_inf || (!w_zero && w_ovf)) begin
      w_resData = {r_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      w_resStat = ST_OVERFLOW;
    end else if (w_zero) begin
      w_resData = '0;
      w_resStat = ST_EXACT;
    end else if (w_unf) begin
      w_resData = {r_sign, {(W-1){1'b0}}};
      w_resStat = ST_UNDERFLOW;
    end else begin
      w_resData = {r_sign, w_expFinal[EXP_W-1:0], w_fracFinal};
      w_resStat = w_inexact ? ST_INEXACT : ST_EXACT;
    end
  end

  // Control FSM and all datapath/output registers; reset aborts any operation.
  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dataOut   <= '0;
      r_statusOut <= '0;
      r_opA       <= '0;
      r_opB       <= '0;
      r_sign      <= 1'b0;
      r_effSub    <= 1'b0;
      r_inf       <= 1'b0;
      r_expL      <= '0;
      r_mantL     <= '0;
      r_mantS     <= '0;
      r_sum       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_opA   <= op_A_in;
            r_opB   <= {op_B_in[W-1] ^ op_sub_in, op_B_in[W-2:0]};
            r_busy  <= 1'b1;
            r_state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          r_sign   <= w_signBig;
          r_effSub <= r_opA[W-1] ^ r_opB[W-1];
          r_inf    <= w_inf;
          r_expL   <= {2'b00, w_expBig};
          r_mantL  <= w_extBig;
          r_mantS  <= w_alignedSmall;
          r_state  <= S_ADD;
        end
        S_ADD: begin
          r_sum   <= r_effSub ? ({1'b0, r_mantL} - {1'b0, r_mantS})
                              : ({1'b0, r_mantL} + {1'b0, r_mantS});
          r_state <= S_NORM;
        end
        S_NORM: begin
          if (r_sum[EXT]) begin
            r_sum   <= {1'b0, r_sum[EXT:2], r_sum[1] | r_sum[0]};
            r_expL  <= r_expL + EXP_ONE;
            r_state <= S_ROUND;
          end else if (w_zero || r_sum[EXT-1]) begin
            r_state <= S_ROUND;
          end else begin
            r_sum  <= r_sum << 1;
            r_expL <= r_expL - EXP_ONE;
          end
        end
        S_ROUND: begin
          r_dataOut   <= w_resData;
          r_statusOut <= w_resStat;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_out   = r_busy;
  assign done_out   = r_done;
  assign data_out   = r_dataOut;
  assign status_out = r_statusOut;

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Directed testbench for fpu_addsub_seq at default parameters (1.0 = 0x3E000000).
module tb_fpu_addsub_seq;

  localparam int W = 32;

  logic          clock100KHz = 1'b0;
  logic          reset;
  logic          start_in;
  logic          op_sub_in;
  logic [W-1:0]  op_A_in;
  logic [W-1:0]  op_B_in;
  logic          busy_out;
  logic          done_out;
  logic [W-1:0]  data_out;
  logic [3:0]    status_out;

  int errors = 0;
  int checks = 0;
  int cycles;
  bit timedOut;
  bit sawDone;

  fpu_addsub_seq #(.EXP_W(6), .MANT_W(25)) dut (
    .clock100KHz (clock100KHz),
    .reset       (reset),
    .start_in    (start_in),
    .op_sub_in   (op_sub_in),
    .op_A_in     (op_A_in),
    .op_B_in     (op_B_in),
    .busy_out    (busy_out),
    .done_out    (done_out),
    .data_out    (data_out),
    .status_out  (status_out)
  );

  // Free-running clock.
  always #5 clock100KHz = ~clock100KHz;

  // Safety net so the run always ends even if something hangs.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: count it, and report tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issue one start pulse and wait (bounded) for done; cycles counts edges from capture.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sub);
    @(negedge clock100KHz);
    op_A_in   = a;
    op_B_in   = b;
    op_sub_in = sub;
    start_in  = 1'b1;
    @(negedge clock100KHz);
    start_in = 1'b0;
    cycles   = 1;
    while (done_out !== 1'b1 && cycles < 60) begin
      @(negedge clock100KHz);
      cycles++;
    end
    timedOut = (done_out !== 1'b1);
  endtask

  // Run one operation and compare result, status, busy and latency bound.
  task automatic runVector(input string tag, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic sub,
                           input logic [W-1:0] expData, input logic [3:0] expStat);
    applyStimulus(a, b, sub);
    checkOutput({tag, " timeout"}, 32'(timedOut), 32'd0);
    checkOutput({tag, " data"}, data_out, expData);
    checkOutput({tag, " status"}, 32'(status_out), 32'(expStat));
    checkOutput({tag, " busy"}, 32'(busy_out), 32'd0);
    checkOutput({tag, " latency<=33"}, 32'(cycles <= 33), 32'd1);
  endtask

  // Directed sequence.
  initial begin
    reset     = 1'b1;
    start_in  = 1'b0;
    op_sub_in = 1'b0;
    op_A_in   = '0;
    op_B_in   = '0;
    repeat (3) @(negedge clock100KHz);
    checkOutput("reset busy", 32'(busy_out), 32'd0);
    checkOutput("reset done", 32'(done_out), 32'd0);
    checkOutput("reset data", data_out, 32'd0);
    checkOutput("reset status", 32'(status_out), 32'd0);
    reset = 1'b0;

    $display("[TB] 1.0 + 1.0 with latency and pulse checks");
    applyStimulus(32'h3E000000, 32'h3E000000, 1'b0);
    checkOutput("1+1 timeout", 32'(timedOut), 32'd0);
    checkOutput("1+1 latency", 32'(cycles), 32'd5);
    checkOutput("1+1 data", data_out, 32'h40000000);
    checkOutput("1+1 status", 32'(status_out), 32'h8);
    @(negedge clock100KHz);
    checkOutput("1+1 done pulse", 32'(done_out), 32'd0);
    checkOutput("1+1 data held", data_out, 32'h40000000);

    runVector("1-1", 32'h3E000000, 32'h3E000000, 1'b1, 32'h00000000, 4'b1000);
    runVector("inf+inf", 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'h7E000000, 4'b0100);
    runVector("inf+1", 32'h7E000000, 32'h3E000000, 1'b0, 32'h7E000000, 4'b0100);
    runVector("max+max", 32'h7DFFFFFF, 32'h7DFFFFFF, 1'b0, 32'h7E000000, 4'b0100);
    runVector("underflow", 32'h02000001, 32'h82000000, 1'b0, 32'h00000000, 4'b0010);
    runVector("tie even", 32'h3E000000, 32'h0A000000, 1'b0, 32'h3E000000, 4'b0001);
    runVector("tie odd", 32'h3E000001, 32'h0A000000, 1'b0, 32'h3E000002, 4'b0001);
    runVector("round carry", 32'h3FFFFFFF, 32'h0A000000, 1'b0, 32'h40000000, 4'b0001);
    runVector("sticky", 32'h3E000000, 32'h02000000, 1'b0, 32'h3E000000, 4'b0001);
    runVector("1.5-1", 32'h3F000000, 32'h3E000000, 1'b1, 32'h3C000000, 4'b1000);
    runVector("1-2", 32'h3E000000, 32'h40000000, 1'b1, 32'hBE000000, 4'b1000);
    runVector("0+1", 32'h00000000, 32'h3E000000, 1'b0, 32'h3E000000, 4'b1000);
    runVector("-1+-1", 32'hBE000000, 32'hBE000000, 1'b0, 32'hC0000000, 4'b1000);
    runVector("1-(-1)", 32'h3E000000, 32'hBE000000, 1'b1, 32'h40000000, 4'b1000);

    $display("[TB] start held high across DONE");
    @(negedge clock100KHz);
    op_A_in   = 32'h3E000000;
    op_B_in   = 32'h3E000000;
    op_sub_in = 1'b0;
    start_in  = 1'b1;
    @(negedge clock100KHz);
    cycles = 1;
    while (done_out !== 1'b1 && cycles < 60) begin
      @(negedge clock100KHz);
      cycles++;
    end
    checkOutput("held first timeout", 32'(done_out !== 1'b1), 32'd0);
    checkOutput("held first data", data_out, 32'h40000000);
    op_A_in   = 32'h3F000000;
    op_B_in   = 32'h3E000000;
    op_sub_in = 1'b1;
    @(negedge clock100KHz);
    checkOutput("held idle busy", 32'(busy_out), 32'd0);
    checkOutput("held idle done", 32'(done_out), 32'd0);
    @(negedge clock100KHz);
    checkOutput("held accepted busy", 32'(busy_out), 32'd1);
    start_in = 1'b0;
    cycles = 1;
    while (done_out !== 1'b1 && cycles < 60) begin
      @(negedge clock100KHz);
      cycles++;
    end
    checkOutput("held second timeout", 32'(done_out !== 1'b1), 32'd0);
    checkOutput("held second latency", 32'(cycles), 32'd6);
    checkOutput("held second data", data_out, 32'h3C000000);
    checkOutput("held second status", 32'(status_out), 32'h8);

    $display("[TB] reset pulsed mid-NORM");
    @(negedge clock100KHz);
    op_A_in   = 32'h02000001;
    op_B_in   = 32'h82000000;
    op_sub_in = 1'b0;
    start_in  = 1'b1;
    @(negedge clock100KHz);
    start_in = 1'b0;
    repeat (3) @(negedge clock100KHz);
    checkOutput("pre-reset busy", 32'(busy_out), 32'd1);
    reset = 1'b1;
    @(negedge clock100KHz);
    checkOutput("abort busy", 32'(busy_out), 32'd0);
    checkOutput("abort done", 32'(done_out), 32'd0);
    checkOutput("abort data", data_out, 32'd0);
    checkOutput("abort status", 32'(status_out), 32'd0);
    reset   = 1'b0;
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clock100KHz);
      if (done_out === 1'b1) sawDone = 1'b1;
    end
    checkOutput("abort no done", 32'(sawDone), 32'd0);
    runVector("after abort", 32'h3E000000, 32'h3E000000, 1'b0, 32'h40000000, 4'b1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
